apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- APB requester: converts a simple valid/ready command port into compliant APB transfers (SETUP then ACCESS) toward the team's APB register slaves.
- Returns one response per command: read data plus error flag.
- Sits between a local controller or CPU-side sequencer and the APB slave fabric. Drives PSEL/PENABLE/PWRITE/PADDR/PWDATA; samples PRDATA/PREADY/PSLVERR.

Parameters:
AWIDTH, 8, address width of PADDR and cmd_addr
DWIDTH, 8, data width of PWDATA/PRDATA and command/response data
TIMEOUT, 16, max ACCESS cycles with PREADY low before forced error completion; 0 disables timeout

Ports:
PCLK  input  1  clock, all logic on rising edge
PRESETn  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  AWIDTH  target address
cmd_wdata  input  DWIDTH  write data
rsp_valid  output  1  one-cycle pulse, transfer complete
rsp_rdata  output  DWIDTH  read data (0 for writes and for timeouts)
rsp_err  output  1  PSLVERR or timeout on the completed transfer
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction
PADDR  output  AWIDTH  APB address
PWDATA  output  DWIDTH  APB write data
PRDATA  input  DWIDTH  APB read data
PREADY  input  1  APB ready (slave wait states)
PSLVERR  input  1  APB slave error

Behaviour:
- Reset (async, PRESETn low): state IDLE. All registered outputs are 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err. Wait counter 0. An in-flight transfer is abandoned with no response.
- States:
  - IDLE: cmd_ready=1 (combinational from state), PSEL=0, PENABLE=0. On handshake, register cmd_write/addr/wdata into PWRITE/PADDR/PWDATA and go to SETUP.
  - SETUP (1 cycle): PSEL=1, PENABLE=0. Always go to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1. Stay while PREADY=0 and timeout not reached.
- cmd_ready=0 in SETUP and ACCESS. Commands are never queued.
- ACCESS completion on rising edge with PREADY=1:
  - rsp_valid=1 next cycle.
  - rsp_rdata = PRDATA if read, else 0.
  - rsp_err = PSLVERR.
  - PSEL=0, PENABLE=0, return to IDLE.
- PSLVERR and PRDATA are sampled only on the completing edge.
- Timeout: wait counter increments each ACCESS cycle with PREADY=0 and clears on entry to SETUP.
  - If TIMEOUT!=0 and counter reaches TIMEOUT with PREADY still 0: complete with rsp_err=1, rsp_rdata=0, return to IDLE.
  - PREADY=1 on that same edge wins: normal completion.
- Latency: handshake at edge N → SETUP cycle N+1 → ACCESS cycle N+2. With zero wait states, rsp_valid and cmd_ready=1 in cycle N+3. Minimum 3 cycles per command.
- PADDR/PWDATA/PWRITE are stable from SETUP through completion and hold their last values in IDLE. PWDATA is updated for reads too (value don't-care on the bus).
- rsp_valid is a single-cycle pulse with no backpressure. rsp_rdata/rsp_err hold until the next completion.
- cmd_valid during SETUP/ACCESS is ignored; cmd fields may change freely while cmd_ready=0.

Test Plan:
- Write 0xA5 to addr 0x03, PREADY tied 1 → PSEL rises N+1, PENABLE N+2, PWDATA=0xA5, PWRITE=1. rsp_valid in N+3 with rsp_err=0, rsp_rdata=0.
- Read addr 0x10, PREADY low 3 ACCESS cycles, PRDATA=0x5C when PREADY=1 → PENABLE high 4 cycles, address stable. rsp_rdata=0x5C, rsp_err=0.
- Write with PSLVERR=1 on completing cycle → rsp_err=1. The next command's response has rsp_err=0.
- TIMEOUT=4, PREADY held 0 → ACCESS ends after 4 wait cycles, rsp_err=1, rsp_rdata=0, PSEL drops. PREADY rising on the 4th edge instead gives a normal response.
- cmd_valid held high for 3 back-to-back commands (write 0x11, read, write 0x22) → exactly 3 responses, one every 3 cycles, in order. No command lost or duplicated.
- PRESETn asserted mid-ACCESS → all outputs 0 immediately, no rsp_valid. After release, cmd_ready=1 and the next command completes normally.

Source files
------------

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Brief    : valid/ready command port to APB requester, one response per cmd
// Revision : 1.0
// ============================================================================
module apb_master_bridge #(
  parameter int AWIDTH  = 8,
  parameter int DWIDTH  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [AWIDTH-1:0] PADDR,
  output logic [DWIDTH-1:0] PWDATA,
  input  logic [DWIDTH-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  // Bit 0 = PSEL, bit 1 = PENABLE, so bus strobes decode straight from flops.
  localparam logic [1:0] c_IDLE   = 2'b00;
  localparam logic [1:0] c_SETUP  = 2'b01;
  localparam logic [1:0] c_ACCESS = 2'b11;

  localparam int          c_CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [31:0] c_TO_LAST = 32'(TIMEOUT - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_CNT_W-1:0] r_wait_cnt;
  logic               w_hs;
  logic               w_timeout;
  logic               w_done;

  assign w_hs      = cmd_valid && cmd_ready;
  // Last permitted wait cycle; a PREADY on the same edge still completes normally.
  assign w_timeout = (TIMEOUT != 0) && !PREADY && (32'(r_wait_cnt) == c_TO_LAST);
  assign w_done    = (r_state == c_ACCESS) && (PREADY || w_timeout);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:   if (w_hs) w_state_nxt = c_SETUP;
      c_SETUP:  w_state_nxt = c_ACCESS;
      c_ACCESS: if (w_done) w_state_nxt = c_IDLE;
      default:  w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (r_state == c_IDLE);
    PSEL      = r_state[0];
    PENABLE   = r_state[1];
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      r_wait_cnt <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= w_done;
      if (w_hs) begin
        PWRITE     <= cmd_write;
        PADDR      <= cmd_addr;
        PWDATA     <= cmd_wdata;
        r_wait_cnt <= '0;
      end else if ((r_state == c_ACCESS) && !PREADY) begin
        r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
      end
      if (w_done) begin
        rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
        rsp_err   <= PREADY ? PSLVERR : 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_bridge
// Brief    : directed bench for apb_master_bridge with a TIMEOUT of 4
// Revision : 1.0
// ============================================================================
module tb_apb_master_bridge;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA, PRDATA;
  logic       PREADY, PSLVERR;

  int n_vec = 0;
  int n_err = 0;

  apb_master_bridge #(.AWIDTH(8), .DWIDTH(8), .TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready} !== 6'b000001) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 000001", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready});
    end
    n_vec++;
    if ({PADDR, PWDATA, rsp_rdata} !== 24'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h want 000000", {PADDR, PWDATA, rsp_rdata});
    end
    step();
    step();
    PRESETn = 1'b1;
    step();
  endtask

  task automatic test_write();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h03; cmd_wdata = 8'hA5;
    PREADY = 1'b1; PSLVERR = 1'b0;
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL wr_ready: got %b want 1", cmd_ready);
    end
    step();
    cmd_valid = 1'b0; cmd_addr = 8'hFF; cmd_wdata = 8'h00;
    n_vec++;
    if ({PSEL, PENABLE, PWRITE, cmd_ready, PADDR, PWDATA} !== {4'b1010, 8'h03, 8'hA5}) begin
      n_err++;
      $display("FAIL wr_setup: got %b %h %h want 1010 03 a5", {PSEL, PENABLE, PWRITE, cmd_ready}, PADDR, PWDATA);
    end
    step();
    n_vec++;
    if ({PSEL, PENABLE, cmd_ready, rsp_valid, PADDR} !== {4'b1100, 8'h03}) begin
      n_err++;
      $display("FAIL wr_access: got %b %h want 1100 03", {PSEL, PENABLE, cmd_ready, rsp_valid}, PADDR);
    end
    step();
    n_vec++;
    if ({rsp_valid, rsp_err, PSEL, PENABLE, cmd_ready, rsp_rdata} !== {5'b10001, 8'h00}) begin
      n_err++;
      $display("FAIL wr_rsp: got %b %h want 10001 00", {rsp_valid, rsp_err, PSEL, PENABLE, cmd_ready}, rsp_rdata);
    end
    n_vec++;
    if ({PWRITE, PADDR, PWDATA} !== {1'b1, 8'h03, 8'hA5}) begin
      n_err++; $display("FAIL wr_hold: got %h want 103a5", {PWRITE, PADDR, PWDATA});
    end
    step();
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL wr_pulse: rsp_valid got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_timeout();
    int n;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h40; cmd_wdata = 8'h00;
    PREADY = 1'b0; PRDATA = 8'hFF;
    step();
    cmd_valid = 1'b0;
    step();
    n = 0;
    while (PENABLE === 1'b1 && n < 10) begin
      n++;
      step();
    end
    n_vec++;
    if (n != 4) begin
      n_err++; $display("FAIL to_cycles: ACCESS cycles got %0d want 4", n);
    end
    n_vec++;
    if ({rsp_valid, rsp_err, PSEL, PENABLE, rsp_rdata} !== {4'b1100, 8'h00}) begin
      n_err++;
      $display("FAIL to_rsp: got %b %h want 1100 00", {rsp_valid, rsp_err, PSEL, PENABLE}, rsp_rdata);
    end
    step();
  endtask

  task automatic test_read_wait();
    int en;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10; cmd_wdata = 8'h3A;
    PREADY = 1'b0; PRDATA = 8'hEE;
    step();
    cmd_valid = 1'b0; cmd_addr = 8'h77;
    step();
    en = 0;
    for (int i = 0; i < 3; i++) begin
      if (PENABLE === 1'b1 && PADDR === 8'h10 && rsp_valid === 1'b0) en++;
      step();
    end
    // Fourth ACCESS cycle: PREADY arrives on the edge that would otherwise time out.
    if (PENABLE === 1'b1 && PADDR === 8'h10) en++;
    PREADY = 1'b1; PRDATA = 8'h5C;
    step();
    PRDATA = 8'h00;
    n_vec++;
    if (en != 4) begin
      n_err++; $display("FAIL rd_wait: stable ACCESS cycles got %0d want 4", en);
    end
    n_vec++;
    if ({rsp_valid, rsp_err, PSEL, rsp_rdata} !== {3'b100, 8'h5C}) begin
      n_err++;
      $display("FAIL rd_rsp: got %b %h want 100 5c", {rsp_valid, rsp_err, PSEL}, rsp_rdata);
    end
    step();
  endtask

  task automatic test_slverr();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h20; cmd_wdata = 8'h77;
    PREADY = 1'b1; PSLVERR = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    PSLVERR = 1'b0;
    n_vec++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 8'h00}) begin
      n_err++; $display("FAIL slverr_rsp: got %b %h want 11 00", {rsp_valid, rsp_err}, rsp_rdata);
    end
    step();
    n_vec++;
    if ({rsp_valid, rsp_err} !== 2'b01) begin
      n_err++; $display("FAIL slverr_hold: got %b want 01", {rsp_valid, rsp_err});
    end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h21; PRDATA = 8'h3C;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    n_vec++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 8'h3C}) begin
      n_err++; $display("FAIL slverr_next: got %b %h want 10 3c", {rsp_valid, rsp_err}, rsp_rdata);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] a_addr [0:2];
    logic [7:0] a_wd   [0:2];
    logic       a_wr   [0:2];
    logic [7:0] s_addr [0:3];
    logic [7:0] s_wd   [0:3];
    logic       s_wr   [0:3];
    logic [7:0] r_data [0:3];
    logic       r_err  [0:3];
    int         r_cyc  [0:3];
    int idx, ns, nr;
    logic hs;
    a_addr[0] = 8'h01; a_wd[0] = 8'h11; a_wr[0] = 1'b1;
    a_addr[1] = 8'h02; a_wd[1] = 8'h00; a_wr[1] = 1'b0;
    a_addr[2] = 8'h03; a_wd[2] = 8'h22; a_wr[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_addr[i] = 'x; s_wd[i] = 'x; s_wr[i] = 'x; r_data[i] = 'x; r_err[i] = 'x; r_cyc[i] = -1;
    end
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 8'h99;
    idx = 0; ns = 0; nr = 0;
    cmd_valid = 1'b1; cmd_write = a_wr[0]; cmd_addr = a_addr[0]; cmd_wdata = a_wd[0];
    for (int cyc = 0; cyc < 14; cyc++) begin
      hs = cmd_valid && cmd_ready;
      step();
      if (hs) begin
        idx++;
        if (idx < 3) begin
          cmd_write = a_wr[idx]; cmd_addr = a_addr[idx]; cmd_wdata = a_wd[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (PSEL === 1'b1 && PENABLE === 1'b0) begin
        if (ns < 4) begin s_addr[ns] = PADDR; s_wd[ns] = PWDATA; s_wr[ns] = PWRITE; end
        ns++;
      end
      if (rsp_valid === 1'b1) begin
        if (nr < 4) begin r_data[nr] = rsp_rdata; r_err[nr] = rsp_err; r_cyc[nr] = cyc; end
        nr++;
      end
    end
    n_vec++;
    if (nr != 3 || ns != 3) begin
      n_err++; $display("FAIL b2b_count: responses %0d setups %0d want 3 3", nr, ns);
    end
    n_vec++;
    if (r_cyc[0] != 2 || r_cyc[1] != 5 || r_cyc[2] != 8) begin
      n_err++; $display("FAIL b2b_timing: rsp cycles %0d %0d %0d want 2 5 8", r_cyc[0], r_cyc[1], r_cyc[2]);
    end
    n_vec++;
    if ({r_data[0], r_data[1], r_data[2], r_err[0], r_err[1], r_err[2]} !== {8'h00, 8'h99, 8'h00, 3'b000}) begin
      n_err++;
      $display("FAIL b2b_rsp: rdata %h %h %h err %b%b%b want 00 99 00 000", r_data[0], r_data[1], r_data[2], r_err[0], r_err[1], r_err[2]);
    end
    n_vec++;
    if ({s_addr[0], s_addr[1], s_addr[2], s_wr[0], s_wr[1], s_wr[2], s_wd[0], s_wd[2]} !==
        {8'h01, 8'h02, 8'h03, 3'b101, 8'h11, 8'h22}) begin
      n_err++;
      $display("FAIL b2b_setup: addr %h %h %h wr %b%b%b wd %h %h want 01 02 03 101 11 22",
               s_addr[0], s_addr[1], s_addr[2], s_wr[0], s_wr[1], s_wr[2], s_wd[0], s_wd[2]);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h55; cmd_wdata = 8'h66;
    PREADY = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    PRESETn = 1'b0;
    #1;
    n_vec++;
    if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready, PADDR, PWDATA, rsp_rdata} !== {6'b000001, 24'h0}) begin
      n_err++;
      $display("FAIL rstmid_out: got %b %h %h %h want 000001 00 00 00",
               {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready}, PADDR, PWDATA, rsp_rdata);
    end
    PREADY = 1'b1;
    seen = 0;
    step();
    if (rsp_valid !== 1'b0) seen++;
    step();
    if (rsp_valid !== 1'b0) seen++;
    PRESETn = 1'b1;
    step();
    if (rsp_valid !== 1'b0 || PSEL !== 1'b0) seen++;
    step();
    if (rsp_valid !== 1'b0 || PSEL !== 1'b0) seen++;
    n_vec++;
    if (seen != 0) begin
      n_err++; $display("FAIL rstmid_norsp: spurious activity in %0d cycles want 0", seen);
    end
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL rstmid_ready: got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h0A; PRDATA = 8'h42;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    n_vec++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 8'h42}) begin
      n_err++; $display("FAIL rstmid_next: got %b %h want 10 42", {rsp_valid, rsp_err}, rsp_rdata);
    end
  endtask

  initial begin
    PRESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    PRDATA = 8'h00; PREADY = 1'b0; PSLVERR = 1'b0;
    test_reset();
    test_write();
    test_timeout();
    test_read_wait();
    test_slverr();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
